// File: rtl/banco_registros_param.sv
// Parametrised register file: N_READ combinational read ports, one write port, x0 hardwired to 0,
// sequential clear sweep after reset. Define BANCO_BYPASS_EN to forward write data to matching read ports.
module banco_registros_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_READ = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [N_READ*ADDR_W-1:0]   readReg,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic [DATA_W-1:0]          writeData,
  input  logic                       RegWrite,
  output logic [N_READ*DATA_W-1:0]   readData,
  output logic                       Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                clr_en, wr_en;

  // Index 0 has no storage; reads of address 0 are forced to zero below.
  logic [DATA_W-1:0]   regs_q [1:DEPTH-1];
  logic [DATA_W-1:0]   regs_d [1:DEPTH-1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    clr_en  = 1'b0;
    wr_en   = 1'b0;
    if (RESET) begin
      state_d = CLEARING;
      ptr_d   = ADDR_W'(1);
      busy_d  = 1'b1;
    end else if (state_q == CLEARING) begin
      clr_en = 1'b1;
      ptr_d  = ptr_q + ADDR_W'(1);
      if (ptr_q == {ADDR_W{1'b1}}) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    end else begin
      wr_en = RegWrite && (writeReg != '0);
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    ptr_q   <= ptr_d;
    busy_q  <= busy_d;
  end

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (clr_en && (ptr_q == ADDR_W'(i))) begin
        regs_d[i] = '0;
      end else if (wr_en && (writeReg == ADDR_W'(i))) begin
        regs_d[i] = writeData;
      end
    end
  end

  // Storage is zeroed by the sweep, so the array itself carries no reset.
  always_ff @(posedge CLK) begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  generate
    for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] rd_data;

      assign rd_addr = readReg[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd_data = '0;
        if (!busy_q && (rd_addr != '0)) begin
          rd_data = regs_q[rd_addr];
`ifdef BANCO_BYPASS_EN
          if (RegWrite && (writeReg == rd_addr)) begin
            rd_data = writeData;
          end
`endif
        end
      end

      assign readData[gi*DATA_W +: DATA_W] = rd_data;
    end
  endgenerate

  assign Busy = busy_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed self-checking bench for banco_registros_param at default parameters.
// Expected bypass behaviour follows BANCO_BYPASS_EN.
module tb_banco_registros_param;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [9:0]  readReg = '0;
  logic [4:0]  writeReg = '0;
  logic [31:0] writeData = '0;
  logic        RegWrite = 1'b0;
  logic [63:0] readData;
  logic        Busy;

  int n_vec = 0;
  int n_err = 0;
  int edges;
  bit nz;

`ifdef BANCO_BYPASS_EN
  localparam logic [31:0] BYP_PRE = 32'h12345678;
`else
  localparam logic [31:0] BYP_PRE = 32'h0;
`endif

  banco_registros_param #(.DATA_W(32), .ADDR_W(5), .N_READ(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .readReg   (readReg),
    .writeReg  (writeReg),
    .writeData (writeData),
    .RegWrite  (RegWrite),
    .readData  (readData),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  function automatic logic [9:0] addrs(input int p1, input int p0);
    return {5'(p1), 5'(p0)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Counts edges until Busy is seen low (bounded), flags any nonzero read on the way,
  // and drives a one-edge write of x3 after wr_at edges (0 = no write).
  task automatic sweep(input int wr_at, output int n_edges, output bit saw_nz);
    n_edges = 0;
    saw_nz  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK);
      n_edges++;
      @(negedge CLK);
      writeReg  = 5'd3;
      writeData = 32'hFFFFFFFF;
      RegWrite  = (wr_at != 0) && (n_edges == wr_at);
      if (readData !== 64'h0) saw_nz = 1'b1;
      if (Busy !== 1'b1) break;
    end
    RegWrite = 1'b0;
  endtask

  initial begin
    // Power-up reset held for two edges
    RESET = 1'b1;
    tick();
    tick();
    check("busy_in_reset", 64'(Busy), 64'h1);
    check("rd_in_reset", readData, 64'h0);
    RESET = 1'b0;
    sweep(0, edges, nz);
    check("sweep1_len", 64'(edges), 64'd31);
    check("sweep1_rd_zero", 64'(nz), 64'h0);
    check("busy_idle", 64'(Busy), 64'h0);
    for (int a = 1; a < 32; a++) begin
      readReg = addrs(a, a);
      #1;
      check($sformatf("x%0d_clear", a), readData, 64'h0);
    end

    // x0 is hardwired
    readReg   = addrs(0, 0);
    writeReg  = 5'd0;
    writeData = 32'h000000A1;
    RegWrite  = 1'b1;
    #1;
    check("x0_pre", 64'(readData[31:0]), 64'h0);
    tick();
    RegWrite = 1'b0;
    #1;
    check("x0_post", 64'(readData[31:0]), 64'h0);

    // Write x5, read it on both ports, x6 untouched
    writeReg  = 5'd5;
    writeData = 32'hDEADBEEF;
    RegWrite  = 1'b1;
    tick();
    RegWrite = 1'b0;
    readReg  = addrs(5, 5);
    #1;
    check("x5_both_ports", readData, {32'hDEADBEEF, 32'hDEADBEEF});
    readReg = addrs(5, 6);
    #1;
    check("x6_zero_x5_p1", readData, {32'hDEADBEEF, 32'h0});

    // Same-cycle write/read of x7
    readReg   = addrs(7, 0);
    writeReg  = 5'd7;
    writeData = 32'h12345678;
    RegWrite  = 1'b1;
    #1;
    check("x7_before_edge", 64'(readData[63:32]), 64'(BYP_PRE));
    tick();
    RegWrite = 1'b0;
    #1;
    check("x7_after_edge", 64'(readData[63:32]), 64'h12345678);

    // Reset with stale data visible on the ports, write of x3 mid-sweep must be dropped
    readReg = addrs(7, 5);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    sweep(5, edges, nz);
    check("sweep2_len", 64'(edges), 64'd31);
    check("sweep2_rd_zero", 64'(nz), 64'h0);
    readReg = addrs(5, 3);
    #1;
    check("x3_dropped", readData, 64'h0);

    // Preload x20, then reset and pulse reset again 10 edges into the sweep
    writeReg  = 5'd20;
    writeData = 32'hAAAA5555;
    RegWrite  = 1'b1;
    tick();
    RegWrite = 1'b0;
    readReg  = addrs(20, 20);
    #1;
    check("x20_preload", readData, {32'hAAAA5555, 32'hAAAA5555});
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (10) tick();
    check("busy_mid_sweep", 64'(Busy), 64'h1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    sweep(0, edges, nz);
    check("sweep3_len", 64'(edges), 64'd31);
    check("sweep3_rd_zero", 64'(nz), 64'h0);
    readReg = addrs(20, 7);
    #1;
    check("x20_x7_cleared", readData, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
